// File: rtl/ps2_scan_receiver.sv
// rtl/ps2_scan_receiver.sv - PS/2 keyboard scan-code receiver with make/break/extended decoding
//
// Purpose:
//   Receives 11-bit PS/2 frames (start, 8 data LSB first, odd parity, stop)
//   from a keyboard. It decodes the 0xF0 break prefix and the 0xE0 extended
//   prefix, and presents only make codes downstream.
//
// Optional feature:
//   PS2_PARITY_CHECK_EN - when defined, a frame whose 8 data bits plus the
//   parity bit do not have odd total parity is rejected. When undefined, the
//   parity bit is consumed and ignored, and only the stop bit decides
//   whether the frame is valid.
//
// Parameters:
//   TIMEOUT      - clock cycles without a PS/2 clock edge mid-frame before
//                  the frame is aborted (16..65535)
//
// Ports:
//   i_clock      - system clock; all state changes on its rising edge
//   i_reset      - asynchronous active-high reset
//   i_ps2_clk    - raw PS/2 clock, asynchronous to i_clock
//   i_ps2_data   - raw PS/2 data, asynchronous to i_clock
//   o_scan_code  - last accepted make code
//   o_scan_valid - one-cycle pulse when o_scan_code is new
//   o_extended   - o_scan_code was preceded by the 0xE0 prefix
//   o_frame_err  - one-cycle pulse on a rejected or timed-out frame

module ps2_scan_receiver #(
    parameter int TIMEOUT = 2000
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic [7:0] o_scan_code,
    output logic       o_scan_valid,
    output logic       o_extended,
    output logic       o_frame_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    // Synchronizers. They reset to 1, the idle bus level, so that releasing
    // reset cannot produce a false falling edge.
    logic r_clk_s1, r_clk_s2, r_clk_prev;
    logic r_data_s1, r_data_s2;

    state_t      r_state;
    state_t      w_next_state;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic [15:0] r_tmo_cnt;
    logic        r_break;
    logic        r_ext;

    logic        w_edge;
    logic        w_timeout;
    logic        w_edge_ok;
    logic        w_shift_en;
    logic        w_frame_done;
    logic        w_parity_ok;
    logic        w_good;

`ifdef PS2_PARITY_CHECK_EN
    logic        r_parity;
`endif

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_data_s1  <= 1'b1;
            r_data_s2  <= 1'b1;
        end else begin
            r_clk_s1   <= i_ps2_clk;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_data_s1  <= i_ps2_data;
            r_data_s2  <= r_data_s1;
        end
    end

    assign w_edge    = r_clk_prev & ~r_clk_s2;
    assign w_timeout = (r_state != ST_IDLE) && (r_tmo_cnt == TMO_LAST);
    // The timeout takes priority, so an edge in the firing cycle is dropped.
    assign w_edge_ok = w_edge & ~w_timeout;

    always_comb begin
        w_next_state = r_state;
        w_shift_en   = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_edge_ok && !r_data_s2) begin
                    w_next_state = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_edge_ok) begin
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == 3'd7) begin
                        w_next_state = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (w_edge_ok) begin
                    w_next_state = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_edge_ok) begin
                    w_next_state = ST_IDLE;
                    w_frame_done = 1'b1;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
        if (w_timeout) begin
            w_next_state = ST_IDLE;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'h00;
            r_tmo_cnt <= 16'd0;
        end else begin
            if (r_state == ST_IDLE || w_timeout) begin
                r_bit_cnt <= 3'd0;
            end else if (w_shift_en) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end

            if (w_shift_en) begin
                r_shift <= {r_data_s2, r_shift[7:1]};
            end

            if (r_state == ST_IDLE || w_timeout || w_edge) begin
                r_tmo_cnt <= 16'd0;
            end else begin
                r_tmo_cnt <= r_tmo_cnt + 16'd1;
            end
        end
    end

`ifdef PS2_PARITY_CHECK_EN
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_parity <= 1'b0;
        end else if (r_state == ST_PARITY && w_edge_ok) begin
            r_parity <= r_data_s2;
        end
    end

    // Odd parity: the nine bits together must hold an odd number of ones.
    assign w_parity_ok = ^{r_shift, r_parity};
`else
    assign w_parity_ok = 1'b1;
`endif

    // The stop bit is the data sampled on the edge that completes the frame.
    assign w_good = r_data_s2 & w_parity_ok;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_scan_code  <= 8'h00;
            o_scan_valid <= 1'b0;
            o_extended   <= 1'b0;
            o_frame_err  <= 1'b0;
            r_break      <= 1'b0;
            r_ext        <= 1'b0;
        end else begin
            o_scan_valid <= 1'b0;
            o_frame_err  <= 1'b0;
            if (w_timeout) begin
                // Prefix flags survive an aborted frame.
                o_frame_err <= 1'b1;
            end else if (w_frame_done) begin
                if (!w_good) begin
                    o_frame_err <= 1'b1;
                end else if (r_shift == 8'hF0) begin
                    r_break <= 1'b1;
                end else if (r_shift == 8'hE0) begin
                    r_ext <= 1'b1;
                end else if (r_break) begin
                    // Break code: the key release is swallowed.
                    r_break <= 1'b0;
                    r_ext   <= 1'b0;
                end else begin
                    o_scan_code  <= r_shift;
                    o_extended   <= r_ext;
                    o_scan_valid <= 1'b1;
                    r_ext        <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/ps2_scan_receiver.md
PS2_SCAN_RECEIVER -- requirements
Module: ps2_scan_receiver

Interface
REQ-001 Parameter TIMEOUT, default 2000: number of idle clock cycles mid-frame before the frame is aborted; range 16..65535.
REQ-002 clock  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 ps2_clk  input  1  raw PS/2 clock from the keyboard; asynchronous to clock.
REQ-005 ps2_data  input  1  raw PS/2 data from the keyboard; asynchronous to clock.
REQ-006 scan_code  output  8  last accepted make code; drives the downstream scan-code-to-ASCII translator.
REQ-007 scan_valid  output  1  one-cycle pulse; scan_code is new this cycle.
REQ-008 extended  output  1  high while scan_code was preceded by the 0xE0 prefix.
REQ-009 frame_err  output  1  one-cycle pulse on a rejected frame.

Function
REQ-010 ps2_clk and ps2_data SHALL each pass through a two-flop synchronizer before any use.
REQ-011 A falling edge SHALL be detected when the synchronized ps2_clk is 0 and its previous registered value was 1; ps2_data SHALL be sampled in that cycle.
REQ-012 The FSM SHALL have states IDLE, DATA, PARITY and STOP, with a 3-bit bit counter.
REQ-013 IDLE: an edge with data=0 (start bit) -> DATA with counter=0; an edge with data=1 SHALL be ignored.
REQ-014 DATA: each edge shifts data into the shift register LSB first; after the 8th bit -> PARITY.
REQ-015 PARITY: the edge captures the parity bit -> STOP.
REQ-016 STOP: the edge checks for stop=1 and returns to IDLE; a frame is good if stop=1 and the parity check (REQ-027) passes.
REQ-017 A bad frame SHALL pulse frame_err for one cycle, the cycle after the stop edge, and SHALL leave flags and scan_code unchanged.
REQ-018 A good byte 0xF0 SHALL set the break flag; 0xE0 SHALL set the ext flag; neither SHALL pulse scan_valid.
REQ-019 Any other good byte with break=1 SHALL be discarded; the byte SHALL then clear both break and ext.
REQ-020 Any other good byte with break=0 SHALL load scan_code, set extended=ext and pulse scan_valid for the cycle after the stop edge; it SHALL then clear ext.
REQ-021 The timeout counter SHALL reset on every detected edge and count while the FSM is not IDLE; at TIMEOUT it SHALL force IDLE, clear the bit counter and pulse frame_err; break and ext SHALL be kept.
REQ-022 An edge arriving in the same cycle the timeout fires SHALL be ignored; the timeout wins.
REQ-023 scan_code and extended SHALL hold between pulses; scan_valid and frame_err SHALL never be high in the same cycle.

Reset
REQ-024 When reset is asserted, every output SHALL go to 0 immediately: scan_code=0x00, scan_valid=0, extended=0, frame_err=0.
REQ-025 Reset SHALL also force FSM=IDLE, clear break, ext and the counters, and set the synchronizer flops to 1 (the idle bus level).
REQ-026 A frame in progress when reset asserts SHALL be dropped; after reset deasserts, reception SHALL restart only on a new start bit.

Configuration
REQ-027 Macro PS2_PARITY_CHECK_EN defined: a frame whose 8 data bits plus parity bit do not have odd total parity SHALL be bad. Undefined: the parity bit SHALL be sampled and ignored, and only the stop bit decides frame validity.

Verification
REQ-028 Frame 0x1C, correct parity, stop=1 -> one scan_valid pulse, scan_code=0x1C, extended=0.
REQ-029 Sequence 0x1C, 0xF0, 0x1C -> exactly one scan_valid pulse (first byte); break flag clear afterwards.
REQ-030 Sequence 0xE0, 0x75 -> scan_valid with scan_code=0x75, extended=1; a following 0x16 -> extended=0.
REQ-031 Frame 0x45 with flipped parity -> with PS2_PARITY_CHECK_EN: frame_err pulse, no scan_valid, scan_code unchanged; without it: scan_valid, scan_code=0x45.
REQ-032 Stop ps2_clk after 4 data bits for TIMEOUT+2 cycles -> one frame_err pulse, FSM IDLE; next full frame 0x26 is received correctly.
REQ-033 Assert reset mid-frame, release it, then send frame 0x3D -> outputs 0 during reset, then scan_code=0x3D with a single scan_valid pulse.
